pixel_simd_serializer: RTL and testbench
========================================

// Module: pixel_simd_serializer
// PURPOSE
//   Output end of the SIMD pixel path. The threshold stage produces SIMD_WIDTH pixels per word.
//   This block accepts those packed words and emits a raster-ordered, one-pixel-per-cycle stream
//   with start-of-frame, end-of-line and end-of-frame markers, feeding the frame writer/DMA.
//   Full throughput: one word every SIMD_WIDTH cycles with no bubbles when both sides are ready.
// PARAMETERS
//   SIMD_WIDTH  4    pixels per input word (>=1)
//   PIX_W       8    bits per pixel
//   WIDTH       64   pixels per row; must be a multiple of SIMD_WIDTH (elaboration $error otherwise)
//   HEIGHT      64   rows per frame (>=1)
// PORTS
//   clk_i        in   1                   clock, rising edge
//   rst_ni       in   1                   asynchronous reset, active low
//   word_i       in   SIMD_WIDTH*PIX_W    packed pixels; lane k = word_i[k*PIX_W +: PIX_W]; lane 0 = leftmost
//   word_valid_i in   1                   word_i valid
//   word_ready_o out  1                   block can accept word_i this cycle
//   pix_o        out  PIX_W               current output pixel
//   pix_valid_o  out  1                   pix_o valid
//   pix_ready_i  in   1                   downstream accepts pix_o
//   sof_o        out  1                   pix_o is row 0, col 0
//   eol_o        out  1                   pix_o is col WIDTH-1
//   eof_o        out  1                   pix_o is row HEIGHT-1, col WIDTH-1
//   col_o        out  $clog2(WIDTH)       column of pix_o
//   row_o        out  $clog2(HEIGHT)      row of pix_o
//   frame_cnt_o  out  16                  completed frames, wraps at 2^16
// BEHAVIOUR
//   - Handshakes: a word transfers when word_valid_i&&word_ready_o. A pixel transfers when
//     pix_valid_o&&pix_ready_i. Valid never drops and data never changes until the transfer completes.
//   - Storage: one word register buf_q, a lane index lane_q, and a state.
//   - FSM states: EMPTY and HOLD.
//     - EMPTY: pix_valid_o=0, word_ready_o=1. On a word transfer: buf_q<=word_i, lane_q<=0, go to HOLD.
//     - HOLD: pix_valid_o=1, pix_o=buf_q lane lane_q. On a pixel transfer with lane_q<SIMD_WIDTH-1:
//       lane_q++ and word_ready_o=0.
//     - HOLD on the last lane (lane_q==SIMD_WIDTH-1): word_ready_o=pix_ready_i (same-cycle refill).
//       If a pixel and a word both transfer: load the new word, lane_q<=0, stay in HOLD.
//       If only the pixel transfers: go to EMPTY.
//     - SIMD_WIDTH==1: every HOLD pixel is the last lane.
//   - Latency: the first pixel is valid 1 cycle after its word transfers. word_ready_o is the only
//     combinational input->output path, from pix_ready_i.
//   - Position counters col_q and row_q (col_o=col_q, row_o=row_q) advance only on a pixel transfer:
//     - col wraps at WIDTH-1 to 0 and then row increments.
//     - row wraps at HEIGHT-1 to 0 and then frame_cnt increments (mod 2^16).
//     - sof_o/eol_o/eof_o are decoded from col_q/row_q and qualified by pix_valid_o.
//   - word_valid_i held low mid-row: stall in EMPTY; counters hold; no pixel is dropped or duplicated.
//   - pix_ready_i low: buf_q, lane_q and counters hold; word_ready_o=0.
//   - Reset (asynchronous assert, any state, including mid-word or mid-frame): state=EMPTY,
//     lane_q=0, col_q=0, row_q=0, frame_cnt_o=0, buf_q=0. Outputs after reset: pix_valid_o=0,
//     word_ready_o=1, pix_o=0, sof_o/eol_o/eof_o=0. A partial word is discarded and the next word
//     starts a new frame at (0,0). Deassertion is expected synchronous to clk_i (external synchronizer).
// TESTING  (WIDTH=8, HEIGHT=2, SIMD_WIDTH=4, PIX_W=8 unless noted)
//   1. Reset, then word 0x04030201 valid one cycle, pix_ready_i=1 -> pix_o 01,02,03,04 on 4
//      consecutive cycles after 1-cycle latency; sof_o only with 01; then pix_valid_o=0 and word_ready_o=1.
//   2. 4 back-to-back words, valid=ready=1 -> 16 pixels with no gaps; eol_o at pixels 8 and 16;
//      eof_o at pixel 16 only; frame_cnt_o=1 after it; the next pixel has sof_o=1, col=row=0.
//   3. pix_ready_i toggled 1010... over a word of 0xFF00FF00 -> output order 00,FF,00,FF; each pixel
//      held stable while stalled; word_ready_o low until the last lane is accepted.
//   4. word_valid_i gap of 5 cycles mid-row after the first word -> pix_valid_o=0 for the gap;
//      next pixel has col_o=4, row_o=0.
//   5. rst_ni asserted after 2 lanes of a word (mid-clock) -> pix_valid_o=0 immediately; after
//      release the next word emits from lane 0 with sof_o=1; frame_cnt_o=0.
//   6. SIMD_WIDTH=1, WIDTH=3, HEIGHT=1, thresholded 00/FF inputs -> pixel per cycle;
//      eof_o=eol_o=1 on every 3rd pixel; frame_cnt_o increments each frame.

Source files
------------

// File: rtl/pixel_simd_serializer.sv
// Unpacks SIMD_WIDTH-pixel words into a raster-ordered one-pixel-per-cycle stream
// with sof/eol/eof markers and a completed-frame counter.
module pixel_simd_serializer #(
   parameter int unsigned SIMD_WIDTH = 4,
   parameter int unsigned PIX_W      = 8,
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned HEIGHT     = 64,
   localparam int unsigned COL_W     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
   localparam int unsigned ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
   localparam int unsigned WORD_W    = SIMD_WIDTH * PIX_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [WORD_W-1:0] word_i,
   input  logic              word_valid_i,
   output logic              word_ready_o,
   output logic [PIX_W-1:0]  pix_o,
   output logic              pix_valid_o,
   input  logic              pix_ready_i,
   output logic              sof_o,
   output logic              eol_o,
   output logic              eof_o,
   output logic [COL_W-1:0]  col_o,
   output logic [ROW_W-1:0]  row_o,
   output logic [15:0]       frame_cnt_o
);

   localparam int unsigned LANE_W = (SIMD_WIDTH > 1) ? $clog2(SIMD_WIDTH) : 1;

   if ((SIMD_WIDTH == 0) || (HEIGHT == 0) || ((WIDTH % SIMD_WIDTH) != 0)) begin : g_bad_params
      $error("pixel_simd_serializer: WIDTH must be a nonzero multiple of SIMD_WIDTH, HEIGHT >= 1");
   end

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t              state_q;
   logic [WORD_W-1:0]   buf_q;
   logic [LANE_W-1:0]   lane_q;
   logic [COL_W-1:0]    col_q;
   logic [ROW_W-1:0]    row_q;
   logic [15:0]         frame_q;

   logic last_lane;
   logic last_col;
   logic last_row;
   logic pix_fire;
   logic word_fire;

   assign last_lane = (lane_q == LANE_W'(SIMD_WIDTH - 1));
   assign last_col  = (col_q == COL_W'(WIDTH - 1));
   assign last_row  = (row_q == ROW_W'(HEIGHT - 1));

   // Ready while empty, or on the last lane when that pixel leaves this cycle (same-cycle refill).
   assign word_ready_o = (state_q == EMPTY) || (last_lane && pix_ready_i);
   assign pix_valid_o  = (state_q == HOLD);
   assign pix_fire     = pix_valid_o && pix_ready_i;
   assign word_fire    = word_valid_i && word_ready_o;

   assign pix_o       = buf_q[PIX_W * 32'(lane_q) +: PIX_W];
   assign col_o       = col_q;
   assign row_o       = row_q;
   assign frame_cnt_o = frame_q;
   assign sof_o       = pix_valid_o && (col_q == '0) && (row_q == '0);
   assign eol_o       = pix_valid_o && last_col;
   assign eof_o       = pix_valid_o && last_col && last_row;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         buf_q   <= '0;
         lane_q  <= '0;
         col_q   <= '0;
         row_q   <= '0;
         frame_q <= '0;
      end else begin
         // Raster position tracks accepted pixels only.
         if (pix_fire) begin
            if (last_col) begin
               col_q <= '0;
               if (last_row) begin
                  row_q   <= '0;
                  frame_q <= frame_q + 16'd1;
               end else begin
                  row_q <= row_q + ROW_W'(1);
               end
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end

         case (state_q)
            EMPTY: begin
               if (word_fire) begin
                  buf_q   <= word_i;
                  lane_q  <= '0;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (pix_fire) begin
                  if (!last_lane) begin
                     lane_q <= lane_q + LANE_W'(1);
                  end else if (word_valid_i) begin
                     buf_q  <= word_i;
                     lane_q <= '0;
                  end else begin
                     lane_q  <= '0;
                     state_q <= EMPTY;
                  end
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_simd_serializer.sv
// Directed bench for pixel_simd_serializer: a 4-lane 8x2 instance and a 1-lane 3x1 instance.
module tb_pixel_simd_serializer;

   logic        clk;
   logic        rst_n;

   logic [31:0] word;
   logic        word_valid;
   logic        word_ready;
   logic [7:0]  pix;
   logic        pix_valid;
   logic        pix_ready;
   logic        sof, eol, eof;
   logic [2:0]  col;
   logic [0:0]  row;
   logic [15:0] frame_cnt;

   logic [7:0]  s_word;
   logic        s_word_valid;
   logic        s_word_ready;
   logic [7:0]  s_pix;
   logic        s_pix_valid;
   logic        s_pix_ready;
   logic        s_sof, s_eol, s_eof;
   logic [1:0]  s_col;
   logic [0:0]  s_row;
   logic [15:0] s_frame_cnt;

   int errors = 0;
   int checks = 0;

   pixel_simd_serializer #(.SIMD_WIDTH(4), .PIX_W(8), .WIDTH(8), .HEIGHT(2)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .word_i(word), .word_valid_i(word_valid), .word_ready_o(word_ready),
      .pix_o(pix), .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
      .sof_o(sof), .eol_o(eol), .eof_o(eof),
      .col_o(col), .row_o(row), .frame_cnt_o(frame_cnt)
   );

   pixel_simd_serializer #(.SIMD_WIDTH(1), .PIX_W(8), .WIDTH(3), .HEIGHT(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .word_i(s_word), .word_valid_i(s_word_valid), .word_ready_o(s_word_ready),
      .pix_o(s_pix), .pix_valid_o(s_pix_valid), .pix_ready_i(s_pix_ready),
      .sof_o(s_sof), .eol_o(s_eol), .eof_o(s_eof),
      .col_o(s_col), .row_o(s_row), .frame_cnt_o(s_frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mkword(input int k);
      return {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      word = '0; word_valid = 1'b0; pix_ready = 1'b0;
      s_word = '0; s_word_valid = 1'b0; s_pix_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      word = '0; word_valid = 1'b0; pix_ready = 1'b0;
      s_word = '0; s_word_valid = 1'b0; s_pix_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
      checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL reset_word_ready: got %b expected 1", word_ready); end
      checks++; if (pix !== 8'h00) begin errors++; $display("FAIL reset_pix: got %h expected 00", pix); end
      checks++; if ({sof, eol, eof} !== 3'b000) begin errors++; $display("FAIL reset_markers: got %b expected 000", {sof, eol, eof}); end
      checks++; if ({col, row} !== 4'd0) begin errors++; $display("FAIL reset_pos: got col=%0d row=%0d expected 0,0", col, row); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame: got %0d expected 0", frame_cnt); end
      checks++; if (s_pix_valid !== 1'b0) begin errors++; $display("FAIL reset_s_pix_valid: got %b expected 0", s_pix_valid); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_word();
      logic [7:0] exp_pix;
      do_reset();
      word = 32'h04030201; word_valid = 1'b1; pix_ready = 1'b1;
      #1;
      checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL single_ready_empty: got %b expected 1", word_ready); end
      @(posedge clk); #1;
      word_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_pix = 8'(k + 1);
         checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL single_valid k=%0d: got %b expected 1", k, pix_valid); end
         checks++; if (pix !== exp_pix) begin errors++; $display("FAIL single_pix k=%0d: got %h expected %h", k, pix, exp_pix); end
         checks++; if (sof !== (k == 0)) begin errors++; $display("FAIL single_sof k=%0d: got %b expected %b", k, sof, (k == 0)); end
         checks++; if (word_ready !== (k == 3)) begin errors++; $display("FAIL single_ready k=%0d: got %b expected %b", k, word_ready, (k == 3)); end
         @(posedge clk); #1;
      end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b expected 0", pix_valid); end
      checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL single_drain_ready: got %b expected 1", word_ready); end
   endtask

   task automatic test_back_to_back();
      int   widx;
      logic fired;
      logic [7:0] exp_pix;
      do_reset();
      widx = 0; word = mkword(0); word_valid = 1'b1; pix_ready = 1'b1;
      for (int c = 0; c <= 20; c++) begin
         if (c >= 1) begin
            exp_pix = 8'(c);
            checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid c=%0d: got %b expected 1", c, pix_valid); end
            checks++; if (pix !== exp_pix) begin errors++; $display("FAIL b2b_pix c=%0d: got %h expected %h", c, pix, exp_pix); end
            checks++; if (eol !== (c == 8 || c == 16)) begin errors++; $display("FAIL b2b_eol c=%0d: got %b expected %b", c, eol, (c == 8 || c == 16)); end
            checks++; if (eof !== (c == 16)) begin errors++; $display("FAIL b2b_eof c=%0d: got %b expected %b", c, eof, (c == 16)); end
            checks++; if (sof !== (c == 1 || c == 17)) begin errors++; $display("FAIL b2b_sof c=%0d: got %b expected %b", c, sof, (c == 1 || c == 17)); end
            checks++; if (col !== 3'((c - 1) % 8)) begin errors++; $display("FAIL b2b_col c=%0d: got %0d expected %0d", c, col, (c - 1) % 8); end
            checks++; if (row !== 1'(((c - 1) / 8) % 2)) begin errors++; $display("FAIL b2b_row c=%0d: got %0d expected %0d", c, row, ((c - 1) / 8) % 2); end
            checks++; if (frame_cnt !== 16'((c > 16) ? 1 : 0)) begin errors++; $display("FAIL b2b_frame c=%0d: got %0d expected %0d", c, frame_cnt, (c > 16) ? 1 : 0); end
         end
         #1 fired = word_valid && word_ready;
         @(posedge clk); #1;
         if (fired) begin
            widx++;
            if (widx < 5) word = mkword(widx);
            else word_valid = 1'b0;
         end
      end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b expected 0", pix_valid); end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL b2b_end_frame: got %0d expected 1", frame_cnt); end
      checks++; if (col !== 3'd4) begin errors++; $display("FAIL b2b_end_col: got %0d expected 4", col); end
   endtask

   // Continues from the back-to-back position (col 4, frame 1) so reset has state to clear.
   task automatic test_mid_reset();
      word = 32'h04030201; word_valid = 1'b1; pix_ready = 1'b1;
      @(posedge clk); #1;
      word_valid = 1'b0;
      checks++; if (pix !== 8'h01 || col !== 3'd4 || sof !== 1'b0) begin errors++; $display("FAIL mrst_pre: got pix=%h col=%0d sof=%b expected 01,4,0", pix, col, sof); end
      repeat (2) begin @(posedge clk); #1; end
      checks++; if (pix !== 8'h03) begin errors++; $display("FAIL mrst_lane2: got %h expected 03", pix); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b expected 0", pix_valid); end
      checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b expected 1", word_ready); end
      checks++; if (pix !== 8'h00) begin errors++; $display("FAIL mrst_pix: got %h expected 00", pix); end
      checks++; if (frame_cnt !== 16'd0 || col !== 3'd0) begin errors++; $display("FAIL mrst_cnt: got frame=%0d col=%0d expected 0,0", frame_cnt, col); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      word = 32'h0D0C0B0A; word_valid = 1'b1; pix_ready = 1'b1;
      @(posedge clk); #1;
      word_valid = 1'b0;
      checks++; if (pix_valid !== 1'b1 || pix !== 8'h0A) begin errors++; $display("FAIL mrst_after_pix: got v=%b pix=%h expected 1,0a", pix_valid, pix); end
      checks++; if (sof !== 1'b1 || col !== 3'd0 || row !== 1'd0) begin errors++; $display("FAIL mrst_after_sof: got sof=%b col=%0d row=%0d expected 1,0,0", sof, col, row); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mrst_after_frame: got %0d expected 0", frame_cnt); end
      @(posedge clk); #1;
      checks++; if (pix !== 8'h0B) begin errors++; $display("FAIL mrst_after_lane1: got %h expected 0b", pix); end
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL mrst_drain: got %b expected 0", pix_valid); end
   endtask

   task automatic test_stall();
      logic [7:0] exp_lane [4];
      int e;
      exp_lane[0] = 8'h00; exp_lane[1] = 8'hFF; exp_lane[2] = 8'h00; exp_lane[3] = 8'hFF;
      do_reset();
      word = 32'hFF00FF00; word_valid = 1'b1; pix_ready = 1'b0;
      @(posedge clk); #1;
      word_valid = 1'b0;
      e = 0;
      for (int j = 0; j < 12 && e < 4; j++) begin
         pix_ready = (j % 2 == 0);
         #1;
         checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL stall_valid j=%0d: got %b expected 1", j, pix_valid); end
         checks++; if (pix !== exp_lane[e]) begin errors++; $display("FAIL stall_pix j=%0d: got %h expected %h", j, pix, exp_lane[e]); end
         checks++; if (word_ready !== (e == 3 && pix_ready)) begin errors++; $display("FAIL stall_ready j=%0d: got %b expected %b", j, word_ready, (e == 3 && pix_ready)); end
         @(posedge clk); #1;
         if (pix_ready) e++;
      end
      checks++; if (pix_valid !== 1'b0 || word_ready !== 1'b1) begin errors++; $display("FAIL stall_end: got v=%b rdy=%b expected 0,1", pix_valid, word_ready); end
      checks++; if (col !== 3'd4) begin errors++; $display("FAIL stall_col: got %0d expected 4", col); end
   endtask

   task automatic test_gap();
      do_reset();
      word = 32'h04030201; word_valid = 1'b1; pix_ready = 1'b1;
      @(posedge clk); #1;
      word_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++; if (pix !== 8'(k + 1) || col !== 3'(k)) begin errors++; $display("FAIL gap_pre k=%0d: got pix=%h col=%0d expected %h,%0d", k, pix, col, 8'(k + 1), k); end
         @(posedge clk); #1;
      end
      for (int g = 0; g < 5; g++) begin
         checks++; if (pix_valid !== 1'b0 || col !== 3'd4) begin errors++; $display("FAIL gap_idle g=%0d: got v=%b col=%0d expected 0,4", g, pix_valid, col); end
         if (g == 4) begin word = 32'h08070605; word_valid = 1'b1; end
         @(posedge clk); #1;
      end
      word_valid = 1'b0;
      checks++; if (pix_valid !== 1'b1 || pix !== 8'h05) begin errors++; $display("FAIL gap_resume_pix: got v=%b pix=%h expected 1,05", pix_valid, pix); end
      checks++; if (col !== 3'd4 || row !== 1'd0 || sof !== 1'b0) begin errors++; $display("FAIL gap_resume_pos: got col=%0d row=%0d sof=%b expected 4,0,0", col, row, sof); end
      repeat (4) begin @(posedge clk); #1; end
      checks++; if (pix_valid !== 1'b0 || col !== 3'd0 || row !== 1'd1) begin errors++; $display("FAIL gap_eol_wrap: got v=%b col=%0d row=%0d expected 0,0,1", pix_valid, col, row); end
   endtask

   task automatic test_simd1();
      logic [7:0] pat [9];
      pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'hFF; pat[3] = 8'h00; pat[4] = 8'hFF;
      pat[5] = 8'h00; pat[6] = 8'hFF; pat[7] = 8'h00; pat[8] = 8'h00;
      do_reset();
      s_pix_ready = 1'b1;
      for (int n = 0; n < 9; n++) begin
         s_word = pat[n]; s_word_valid = 1'b1;
         @(posedge clk); #1;
         checks++; if (s_pix_valid !== 1'b1 || s_pix !== pat[n]) begin errors++; $display("FAIL simd1_pix n=%0d: got v=%b pix=%h expected 1,%h", n, s_pix_valid, s_pix, pat[n]); end
         checks++; if (s_eol !== (n % 3 == 2) || s_eof !== (n % 3 == 2)) begin errors++; $display("FAIL simd1_eol n=%0d: got eol=%b eof=%b expected %b", n, s_eol, s_eof, (n % 3 == 2)); end
         checks++; if (s_sof !== (n % 3 == 0)) begin errors++; $display("FAIL simd1_sof n=%0d: got %b expected %b", n, s_sof, (n % 3 == 0)); end
         checks++; if (s_col !== 2'(n % 3)) begin errors++; $display("FAIL simd1_col n=%0d: got %0d expected %0d", n, s_col, n % 3); end
         checks++; if (s_frame_cnt !== 16'(n / 3)) begin errors++; $display("FAIL simd1_frame n=%0d: got %0d expected %0d", n, s_frame_cnt, n / 3); end
      end
      s_word_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (s_pix_valid !== 1'b0) begin errors++; $display("FAIL simd1_drain: got %b expected 0", s_pix_valid); end
      checks++; if (s_frame_cnt !== 16'd3) begin errors++; $display("FAIL simd1_frames: got %0d expected 3", s_frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_mid_reset();
      test_stall();
      test_gap();
      test_simd1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
